// File: rtl/bomb_scheduler.sv
// bomb_scheduler: owns the stage's bomb slot table.
//   - Allocates placement requests from both players into a fixed slot pool,
//     arbitrating same-cycle requests with a toggling priority.
//   - Advances each bomb FUSE -> BLAST -> FREE on the 60 Hz tick.
//   - Serialises explosion events, lowest slot first, one per cycle.
//   - Provides combinational per-slot read-back for the draw path.
// Ports:
//   clock, resetn             clock and asynchronous active-low reset
//   tick                      60 Hz single-cycle strobe
//   clear                     synchronous game reset (overrides everything)
//   p1_place/p1_x/p1_y        player 1 placement request and tile
//   p2_place/p2_x/p2_y        player 2 placement request and tile
//   p1_grant, p2_grant        registered accept pulses
//   p1_count, p2_count        live bombs per player
//   bomb_id                   read-back slot index
//   bomb_active/exploding/x/y read-back of the selected slot
//   explode_pulse/x/y         one-cycle explosion event with its tile
module bomb_scheduler #(
    parameter int NUM_BOMBS      = 6,
    parameter int MAX_PER_PLAYER = 3,
    parameter int FUSE_TICKS     = 150,
    parameter int BLAST_TICKS    = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic       clear,
    input  logic       p1_place,
    input  logic [3:0] p1_x,
    input  logic [3:0] p1_y,
    input  logic       p2_place,
    input  logic [3:0] p2_x,
    input  logic [3:0] p2_y,
    output logic       p1_grant,
    output logic       p2_grant,
    output logic [1:0] p1_count,
    output logic [1:0] p2_count,
    input  logic [2:0] bomb_id,
    output logic       bomb_active,
    output logic       bomb_exploding,
    output logic [3:0] bomb_x,
    output logic [3:0] bomb_y,
    output logic       explode_pulse,
    output logic [3:0] explode_x,
    output logic [3:0] explode_y
);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_FUSE, SLOT_BLAST} slot_e;

    localparam logic [7:0] FUSE_LOAD  = 8'(FUSE_TICKS);
    localparam logic [7:0] BLAST_LOAD = 8'(BLAST_TICKS);
    localparam logic [1:0] MAX_CNT    = 2'(MAX_PER_PLAYER);

    slot_e      st    [NUM_BOMBS];
    logic       owner [NUM_BOMBS];   // 0 = player 1, 1 = player 2
    logic [3:0] sx    [NUM_BOMBS];
    logic [3:0] sy    [NUM_BOMBS];
    logic [7:0] tmr   [NUM_BOMBS];
    logic       pend  [NUM_BOMBS];
    logic       prio_p2;

    // Count update with clamping to 0..MAX_PER_PLAYER.
    function automatic logic [1:0] sat_count(input logic [1:0] c, input logic inc, input int dec);
        int v;
        v = int'(c) + int'(inc) - dec;
        if (v < 0) v = 0;
        if (v > MAX_PER_PLAYER) v = MAX_PER_PLAYER;
        return v[1:0];
    endfunction

    // Allocation and arbitration, all on the table state before this cycle.
    int   nfree, f0, f1, slot_a1, slot_a2;
    logic dup1, dup2, q1, q2, acc1, acc2, contested;

    always_comb begin
        nfree = 0;
        f0 = 0;
        f1 = 0;
        dup1 = 1'b0;
        dup2 = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (st[i] == SLOT_FREE) begin
                if (nfree == 0) f0 = i;
                else if (nfree == 1) f1 = i;
                nfree = nfree + 1;
            end else begin
                if (sx[i] == p1_x && sy[i] == p1_y) dup1 = 1'b1;
                if (sx[i] == p2_x && sy[i] == p2_y) dup2 = 1'b1;
            end
        end
        q1 = p1_place && (nfree >= 1) && (p1_count < MAX_CNT) && !dup1;
        q2 = p2_place && (nfree >= 1) && (p2_count < MAX_CNT) && !dup2;

        acc1 = 1'b0;
        acc2 = 1'b0;
        slot_a1 = f0;
        slot_a2 = f0;
        contested = 1'b0;
        if (q1 && q2 && (nfree >= 2) && ((p1_x != p2_x) || (p1_y != p2_y))) begin
            acc1 = 1'b1;
            acc2 = 1'b1;
            slot_a2 = f1;
        end else if (p1_place && p2_place) begin
            // Only the priority player is considered; the loser is dropped.
            contested = 1'b1;
            if (prio_p2) acc2 = q2;
            else         acc1 = q1;
        end else begin
            acc1 = q1;
            acc2 = q2;
        end
    end

    // Owner count decrements from slots leaving BLAST on this tick.
    int dec1, dec2;

    always_comb begin
        dec1 = 0;
        dec2 = 0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (tick && st[i] == SLOT_BLAST && tmr[i] == 8'd1) begin
                if (owner[i]) dec2 = dec2 + 1;
                else          dec1 = dec1 + 1;
            end
        end
    end

    // Explosion serialiser: lowest-index pending slot wins.
    logic       svc_vld;
    int         svc_idx;
    logic [3:0] svc_x, svc_y;

    always_comb begin
        svc_vld = 1'b0;
        svc_idx = 0;
        svc_x   = 4'd0;
        svc_y   = 4'd0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (pend[i] && !svc_vld) begin
                svc_vld = 1'b1;
                svc_idx = i;
                svc_x   = sx[i];
                svc_y   = sy[i];
            end
        end
    end

    // Read-back; out-of-range ids and FREE slots read as zero.
    always_comb begin
        bomb_active    = 1'b0;
        bomb_exploding = 1'b0;
        bomb_x         = 4'd0;
        bomb_y         = 4'd0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (int'(bomb_id) == i && st[i] != SLOT_FREE) begin
                bomb_active    = 1'b1;
                bomb_exploding = (st[i] == SLOT_BLAST);
                bomb_x         = sx[i];
                bomb_y         = sy[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                st[i]    <= SLOT_FREE;
                owner[i] <= 1'b0;
                sx[i]    <= 4'd0;
                sy[i]    <= 4'd0;
                tmr[i]   <= 8'd0;
                pend[i]  <= 1'b0;
            end
            prio_p2       <= 1'b0;
            p1_grant      <= 1'b0;
            p2_grant      <= 1'b0;
            p1_count      <= 2'd0;
            p2_count      <= 2'd0;
            explode_pulse <= 1'b0;
            explode_x     <= 4'd0;
            explode_y     <= 4'd0;
        end else if (clear) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                st[i]    <= SLOT_FREE;
                owner[i] <= 1'b0;
                sx[i]    <= 4'd0;
                sy[i]    <= 4'd0;
                tmr[i]   <= 8'd0;
                pend[i]  <= 1'b0;
            end
            prio_p2       <= 1'b0;
            p1_grant      <= 1'b0;
            p2_grant      <= 1'b0;
            p1_count      <= 2'd0;
            p2_count      <= 2'd0;
            explode_pulse <= 1'b0;
            explode_x     <= 4'd0;
            explode_y     <= 4'd0;
        end else begin
            p1_grant <= acc1;
            p2_grant <= acc2;
            p1_count <= sat_count(p1_count, acc1, dec1);
            p2_count <= sat_count(p2_count, acc2, dec2);
            if (contested) prio_p2 <= ~prio_p2;

            explode_pulse <= svc_vld;
            explode_x     <= svc_x;
            explode_y     <= svc_y;

            for (int i = 0; i < NUM_BOMBS; i++) begin
                if (svc_vld && svc_idx == i) pend[i] <= 1'b0;
                // Newly allocated slots are FREE here, so the tick never touches them.
                if (tick) begin
                    case (st[i])
                        SLOT_FUSE: begin
                            if (tmr[i] == 8'd1) begin
                                st[i]   <= SLOT_BLAST;
                                tmr[i]  <= BLAST_LOAD;
                                pend[i] <= 1'b1;
                            end else begin
                                tmr[i] <= tmr[i] - 8'd1;
                            end
                        end
                        SLOT_BLAST: begin
                            // The pending bit is left alone so a late event still fires.
                            if (tmr[i] == 8'd1) begin
                                st[i]  <= SLOT_FREE;
                                tmr[i] <= 8'd0;
                            end else begin
                                tmr[i] <= tmr[i] - 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (acc1 && slot_a1 == i) begin
                    st[i]    <= SLOT_FUSE;
                    tmr[i]   <= FUSE_LOAD;
                    owner[i] <= 1'b0;
                    sx[i]    <= p1_x;
                    sy[i]    <= p1_y;
                end
                if (acc2 && slot_a2 == i) begin
                    st[i]    <= SLOT_FUSE;
                    tmr[i]   <= FUSE_LOAD;
                    owner[i] <= 1'b1;
                    sx[i]    <= p2_x;
                    sy[i]    <= p2_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Testbench for bomb_scheduler: table-driven vectors plus hand sequences for
// clear, pool-full with same-cycle free, and asynchronous reset.
module tb_bomb_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic       tick, clear;
    logic       p1_place, p2_place;
    logic [3:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_grant, p2_grant;
    logic [1:0] p1_count, p2_count;
    logic [2:0] bomb_id;
    logic       bomb_active, bomb_exploding;
    logic [3:0] bomb_x, bomb_y;
    logic       explode_pulse;
    logic [3:0] explode_x, explode_y;

    int checks = 0;
    int errors = 0;

    bomb_scheduler #(
        .NUM_BOMBS(5), .MAX_PER_PLAYER(3), .FUSE_TICKS(3), .BLAST_TICKS(2)
    ) dut (
        .clock(clock), .resetn(resetn), .tick(tick), .clear(clear),
        .p1_place(p1_place), .p1_x(p1_x), .p1_y(p1_y),
        .p2_place(p2_place), .p2_x(p2_x), .p2_y(p2_y),
        .p1_grant(p1_grant), .p2_grant(p2_grant),
        .p1_count(p1_count), .p2_count(p2_count),
        .bomb_id(bomb_id), .bomb_active(bomb_active), .bomb_exploding(bomb_exploding),
        .bomb_x(bomb_x), .bomb_y(bomb_y),
        .explode_pulse(explode_pulse), .explode_x(explode_x), .explode_y(explode_y)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       p1; logic [3:0] p1x, p1y;
        logic       p2; logic [3:0] p2x, p2y;
        logic       tk; logic [2:0] id;
        logic       g1, g2; logic [1:0] c1, c2;
        logic       ep; logic [3:0] ex, ey;
        logic       act, expl; logic [3:0] bx, by;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic p1, input int p1x, input int p1y,
        input logic p2, input int p2x, input int p2y,
        input logic tk, input int id,
        input logic g1, input logic g2, input int c1, input int c2,
        input logic ep, input int ex, input int ey,
        input logic act, input logic expl, input int bx, input int by);
        vec_t v;
        v.p1 = p1; v.p1x = 4'(p1x); v.p1y = 4'(p1y);
        v.p2 = p2; v.p2x = 4'(p2x); v.p2y = 4'(p2y);
        v.tk = tk; v.id = 3'(id);
        v.g1 = g1; v.g2 = g2; v.c1 = 2'(c1); v.c2 = 2'(c2);
        v.ep = ep; v.ex = 4'(ex); v.ey = 4'(ey);
        v.act = act; v.expl = expl; v.bx = 4'(bx); v.by = 4'(by);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        tick = 1'b0; clear = 1'b0; p1_place = 1'b0; p2_place = 1'b0;
    endtask

    task automatic place(input logic a, input int ax, input int ay,
                         input logic b, input int bx, input int by, input logic tk);
        p1_place = a; p1_x = 4'(ax); p1_y = 4'(ay);
        p2_place = b; p2_x = 4'(bx); p2_y = 4'(by);
        tick = tk;
        step();
        idle();
    endtask

    task automatic chk_rb(input string name, input int id, input int act, input int expl,
                          input int x, input int y);
        bomb_id = 3'(id);
        #1;
        chk({name, ".active"}, int'(bomb_active), act);
        chk({name, ".exploding"}, int'(bomb_exploding), expl);
        chk({name, ".x"}, int'(bomb_x), x);
        chk({name, ".y"}, int'(bomb_y), y);
    endtask

    task automatic chk_all_free(input string name);
        for (int i = 0; i < 8; i++) chk_rb($sformatf("%s.id%0d", name, i), i, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 1'b0;
        bomb_id = 3'd0;
        p1_x = 4'd0; p1_y = 4'd0; p2_x = 4'd0; p2_y = 4'd0;
        idle();

        // Single bomb: place, fuse 3 ticks, explode, blast 2 ticks, free.
        tbl.push_back(mk(1,2,3, 0,0,0, 0,0, 1,0,1,0, 0,0,0, 1,0,2,3));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,1,0, 0,0,0, 1,0,2,3));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,1,0, 0,0,0, 1,0,2,3));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,1,0, 0,0,0, 1,1,2,3));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,1,0, 1,2,3, 1,1,2,3));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,1,0, 0,0,0, 1,1,2,3));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,0, 0,0,0,0));
        // Per-player limit, duplicate tile, out-of-range read-back.
        tbl.push_back(mk(1,1,1, 0,0,0, 0,0, 1,0,1,0, 0,0,0, 1,0,1,1));
        tbl.push_back(mk(1,2,1, 0,0,0, 0,1, 1,0,2,0, 0,0,0, 1,0,2,1));
        tbl.push_back(mk(1,3,1, 0,0,0, 0,2, 1,0,3,0, 0,0,0, 1,0,3,1));
        tbl.push_back(mk(1,4,1, 0,0,0, 0,3, 0,0,3,0, 0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,2,1, 0,1, 0,0,3,0, 0,0,0, 1,0,2,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,5, 0,0,3,0, 0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,6, 0,0,3,0, 0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,7, 0,0,3,0, 0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,5,5, 0,3, 0,1,3,1, 0,0,0, 1,0,5,5));
        // Four bombs expire together: pulses serialised in slot order.
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,3,1, 0,0,0, 1,0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,3,1, 0,0,0, 1,0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,3,1, 0,0,0, 1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3,1, 1,1,1, 1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3,1, 1,2,1, 1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3,1, 1,3,1, 1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3,1, 1,5,5, 1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,3,1, 0,0,0, 1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,3,1, 0,0,0, 1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0,0, 0,0,0,0));
        // Contention: P1 wins, then P2 wins, then distinct tiles both granted.
        tbl.push_back(mk(1,7,7, 1,7,7, 0,0, 1,0,1,0, 0,0,0, 1,0,7,7));
        tbl.push_back(mk(1,8,8, 1,8,8, 0,1, 0,1,1,1, 0,0,0, 1,0,8,8));
        tbl.push_back(mk(1,9,9, 1,10,10, 0,2, 1,1,2,2, 0,0,0, 1,0,9,9));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,3, 0,0,2,2, 0,0,0, 1,0,10,10));
        // Priority player disqualified (duplicate): the other is dropped too.
        tbl.push_back(mk(1,9,9, 1,11,11, 0,4, 0,0,2,2, 0,0,0, 0,0,0,0));
        // Priority has toggled to P2.
        tbl.push_back(mk(1,11,11, 1,11,11, 0,4, 0,1,2,3, 0,0,0, 1,0,11,11));

        // Reset state.
        step();
        step();
        chk("rst.p1_grant", int'(p1_grant), 0);
        chk("rst.p2_grant", int'(p2_grant), 0);
        chk("rst.p1_count", int'(p1_count), 0);
        chk("rst.p2_count", int'(p2_count), 0);
        chk("rst.explode_pulse", int'(explode_pulse), 0);
        chk_all_free("rst");
        resetn = 1'b1;
        step();

        foreach (tbl[k]) begin
            bomb_id = tbl[k].id;
            place(tbl[k].p1, int'(tbl[k].p1x), int'(tbl[k].p1y),
                  tbl[k].p2, int'(tbl[k].p2x), int'(tbl[k].p2y), tbl[k].tk);
            chk($sformatf("v%0d.p1_grant", k), int'(p1_grant), int'(tbl[k].g1));
            chk($sformatf("v%0d.p2_grant", k), int'(p2_grant), int'(tbl[k].g2));
            chk($sformatf("v%0d.p1_count", k), int'(p1_count), int'(tbl[k].c1));
            chk($sformatf("v%0d.p2_count", k), int'(p2_count), int'(tbl[k].c2));
            chk($sformatf("v%0d.explode_pulse", k), int'(explode_pulse), int'(tbl[k].ep));
            if (tbl[k].ep) begin
                chk($sformatf("v%0d.explode_x", k), int'(explode_x), int'(tbl[k].ex));
                chk($sformatf("v%0d.explode_y", k), int'(explode_y), int'(tbl[k].ey));
            end
            chk($sformatf("v%0d.active", k), int'(bomb_active), int'(tbl[k].act));
            chk($sformatf("v%0d.exploding", k), int'(bomb_exploding), int'(tbl[k].expl));
            chk($sformatf("v%0d.bomb_x", k), int'(bomb_x), int'(tbl[k].bx));
            chk($sformatf("v%0d.bomb_y", k), int'(bomb_y), int'(tbl[k].by));
        end

        // Clear overrides a same-cycle placement and empties the table.
        clear = 1'b1;
        place(1, 12, 12, 0, 0, 0, 0);
        chk("clr.p1_grant", int'(p1_grant), 0);
        chk("clr.p1_count", int'(p1_count), 0);
        chk("clr.p2_count", int'(p2_count), 0);
        chk("clr.explode_pulse", int'(explode_pulse), 0);
        chk_all_free("clr");
        place(1, 1, 1, 1, 1, 1, 0);
        chk("clr.prio.p1_grant", int'(p1_grant), 1);
        chk("clr.prio.p2_grant", int'(p2_grant), 0);

        // Fill the pool: P1 holds 3, P2 holds 2; P2's extra request is rejected.
        place(1, 3, 2, 1, 4, 2, 0);
        place(1, 5, 2, 1, 6, 2, 0);
        chk("full.p1_count", int'(p1_count), 3);
        chk("full.p2_count", int'(p2_count), 2);
        place(0, 0, 0, 1, 7, 2, 0);
        chk("full.p2_grant", int'(p2_grant), 0);
        chk("full.p2_count_hold", int'(p2_count), 2);
        place(0, 0, 0, 0, 0, 0, 1);
        place(0, 0, 0, 0, 0, 0, 1);
        place(0, 0, 0, 0, 0, 0, 1);
        place(0, 0, 0, 0, 0, 0, 1);
        // Request lands in the cycle the slots free: still rejected.
        place(0, 0, 0, 1, 7, 2, 1);
        chk("freecyc.p2_grant", int'(p2_grant), 0);
        chk("freecyc.p1_count", int'(p1_count), 0);
        chk("freecyc.p2_count", int'(p2_count), 0);
        place(0, 0, 0, 1, 7, 2, 0);
        chk("retry.p2_grant", int'(p2_grant), 1);
        chk("retry.p2_count", int'(p2_count), 1);
        chk_rb("retry.slot0", 0, 1, 0, 7, 2);

        // Asynchronous reset mid-fuse.
        #3 resetn = 1'b0;
        #1;
        chk("arst.p2_count", int'(p2_count), 0);
        chk("arst.explode_pulse", int'(explode_pulse), 0);
        chk_rb("arst.slot0", 0, 0, 0, 0, 0);
        step();
        resetn = 1'b1;
        step();
        chk("arst.p1_count", int'(p1_count), 0);
        chk("arst.p2_grant", int'(p2_grant), 0);
        chk_all_free("arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
